// File: rtl/lcd_bus_ctrl.sv
// Parallel LCD panel bus controller: panel reset sequencing, then paced
// command/data writes and reads over a split bidirectional 16-bit bus.
module lcd_bus_ctrl #(
    parameter int unsigned T_WRL  = 2,
    parameter int unsigned T_WRH  = 2,
    parameter int unsigned T_RDL  = 5,
    parameter int unsigned T_RDH  = 3,
    parameter int unsigned T_RSTL = 16,
    parameter int unsigned T_RSTW = 64
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rs,
    input  logic        req_rd,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic        init_req,
    input  logic        bl_en,
    output logic        busy,
    output logic        blk,
    output logic        cs,
    output logic        rs,
    output logic        wr,
    output logic        rd,
    output logic        rst,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in
);

    localparam logic [2:0] S_INIT_RST  = 3'd0;
    localparam logic [2:0] S_INIT_WAIT = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_WR_LO     = 3'd3;
    localparam logic [2:0] S_WR_HI     = 3'd4;
    localparam logic [2:0] S_RD_LO     = 3'd5;
    localparam logic [2:0] S_RD_HI     = 3'd6;

    localparam logic [15:0] WRL_LD  = 16'(T_WRL - 1);
    localparam logic [15:0] WRH_LD  = 16'(T_WRH - 1);
    localparam logic [15:0] RDL_LD  = 16'(T_RDL - 1);
    localparam logic [15:0] RDH_LD  = 16'(T_RDH - 1);
    localparam logic [15:0] RSTL_LD = 16'(T_RSTL - 1);
    localparam logic [15:0] RSTW_LD = 16'(T_RSTW - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        accept;
    logic        capture;
    logic        cnt_done;

    assign cnt_done = (cnt_q == 16'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_INIT_RST: begin
                if (cnt_done) begin
                    state_d = S_INIT_WAIT;
                    cnt_d   = RSTW_LD;
                end
            end
            S_INIT_WAIT: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                cnt_d = cnt_q;
                // Re-init wins over a simultaneous request, which stays pending.
                if (init_req) begin
                    state_d = S_INIT_RST;
                    cnt_d   = RSTL_LD;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_rd ? S_RD_LO : S_WR_LO;
                    cnt_d   = req_rd ? RDL_LD : WRL_LD;
                end
            end
            S_WR_LO: begin
                if (cnt_done) begin
                    state_d = S_WR_HI;
                    cnt_d   = WRH_LD;
                end
            end
            S_WR_HI: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_RD_LO: begin
                if (cnt_done) begin
                    state_d = S_RD_HI;
                    cnt_d   = RDH_LD;
                    capture = 1'b1;
                end
            end
            S_RD_HI: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT_RST;
                cnt_d   = RSTL_LD;
            end
        endcase
    end

    // Pin levels are decoded from the next state so every output is a flop.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q   <= S_INIT_RST;
            cnt_q     <= RSTL_LD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cs        <= 1'b1;
            wr        <= 1'b1;
            rd        <= 1'b1;
            rst       <= 1'b0;
            rs        <= 1'b0;
            blk       <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            cs        <= !((state_d == S_WR_LO) || (state_d == S_WR_HI) ||
                           (state_d == S_RD_LO) || (state_d == S_RD_HI));
            wr        <= (state_d != S_WR_LO);
            rd        <= (state_d != S_RD_LO);
            rst       <= (state_d != S_INIT_RST);
            data_oe   <= (state_d == S_WR_LO) || (state_d == S_WR_HI);
            blk       <= bl_en;
            rsp_valid <= capture;
            if (capture) begin
                rsp_data <= data_in;
            end
            if (accept) begin
                rs <= req_rs;
                if (!req_rd) begin
                    data_out <= req_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Scoreboard bench for lcd_bus_ctrl: stimulus pushes expected bus transfers,
// a negedge monitor pops and checks them along with pin timing.
module tb_lcd_bus_ctrl;

    localparam int T_WRL  = 2;
    localparam int T_WRH  = 2;
    localparam int T_RDL  = 5;
    localparam int T_RDH  = 3;
    localparam int T_RSTL = 16;
    localparam int T_RSTW = 64;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rs = 1'b0;
    logic        req_rd = 1'b0;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        init_req = 1'b0;
    logic        bl_en = 1'b0;
    logic        busy, blk, cs, rs, wr, rd, rst;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [16:0] wr_q[$];
    logic [15:0] rd_q[$];

    lcd_bus_ctrl dut (
        .pclk     (pclk),
        .prst     (prst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_rd   (req_rd),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .init_req (init_req),
        .bl_en    (bl_en),
        .busy     (busy),
        .blk      (blk),
        .cs       (cs),
        .rs       (rs),
        .wr       (wr),
        .rd       (rd),
        .rst      (rst),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in)
    );

    initial forever #5 pclk = ~pclk;

    initial forever begin
        @(negedge pclk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Monitor: scoreboard pops on wr falling edge and on rsp_valid.
    logic        prev_wr = 1'b1, prev_rd = 1'b1, prev_prst = 1'b1, prev_bl = 1'b0;
    logic        prev_rsp_valid = 1'b0, have_prev = 1'b0;
    logic        wr_hi_ph = 1'b0, rd_hi_ph = 1'b0;
    int          wr_lo_n = 0, wr_hi_n = 0, rd_lo_n = 0, rd_hi_n = 0;
    logic [16:0] cur_w = '0;

    initial forever begin
        @(negedge pclk);
        if (have_prev) check("blk_follow", blk, prev_prst ? 1'b0 : prev_bl);
        check("wr_rd_overlap", (!wr && !rd), 1'b0);
        check("strobe_without_cs", ((!wr || !rd) && cs), 1'b0);
        check("oe_during_read", (data_oe && !rd), 1'b0);
        if (prev_prst) begin
            wr_hi_ph = 1'b0;
            rd_hi_ph = 1'b0;
            wr_lo_n  = 0;
            rd_lo_n  = 0;
        end else begin
            if (!wr) begin
                if (prev_wr) begin
                    if (wr_q.size() == 0) begin
                        fail_msg("wr_unexpected", $sformatf("rs=%0d data=0x%0h, none expected",
                                                            rs, data_out));
                    end else begin
                        cur_w = wr_q.pop_front();
                        check("wr_rs_data", {rs, data_out}, cur_w);
                    end
                    check("wr_oe", data_oe, 1'b1);
                    wr_lo_n = 0;
                end
                wr_lo_n++;
            end else if (!prev_wr) begin
                check("wr_low_len", wr_lo_n, T_WRL);
                wr_hi_ph = 1'b1;
                wr_hi_n  = 0;
            end
            if (wr_hi_ph) begin
                if (!cs) begin
                    wr_hi_n++;
                    check("wr_hold", {rs, data_out, data_oe}, {cur_w, 1'b1});
                end else begin
                    check("wr_high_len", wr_hi_n, T_WRH);
                    check("wr_oe_release", data_oe, 1'b0);
                    wr_hi_ph = 1'b0;
                end
            end
            if (!rd) begin
                if (prev_rd) rd_lo_n = 0;
                rd_lo_n++;
            end else if (!prev_rd) begin
                check("rd_low_len", rd_lo_n, T_RDL);
                check("rsp_valid_first_hi", rsp_valid, 1'b1);
                rd_hi_ph = 1'b1;
                rd_hi_n  = 0;
            end
            if (rd_hi_ph) begin
                if (!cs) begin
                    rd_hi_n++;
                end else begin
                    check("rd_high_len", rd_hi_n, T_RDH);
                    rd_hi_ph = 1'b0;
                end
            end
        end
        if (rsp_valid) begin
            check("rsp_single_pulse", prev_rsp_valid, 1'b0);
            check("rsp_timing", (rd && !prev_rd && !cs), 1'b1);
            if (rd_q.size() == 0) begin
                fail_msg("rsp_unexpected", $sformatf("rsp_data=0x%0h, none expected", rsp_data));
            end else begin
                check("rsp_data", rsp_data, rd_q.pop_front());
            end
        end
        prev_wr        = wr;
        prev_rd        = rd;
        prev_prst      = prst;
        prev_bl        = bl_en;
        prev_rsp_valid = rsp_valid;
        have_prev      = 1'b1;
    end

    // Backlight toggles continuously, through init and accesses.
    initial forever begin
        repeat (7) @(posedge pclk);
        #1 bl_en = ~bl_en;
    end

    task automatic do_req(input logic wrs, input logic wrd, input logic [15:0] d, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        @(posedge pclk);
        #1;
        req_rs    = wrs;
        req_rd    = wrd;
        req_data  = d;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge pclk);
            if (req_ready) begin
                @(posedge pclk);
                acc = cyc;
                ok  = 1'b1;
            end
        end
        #1 req_valid = 1'b0;
        if (!ok) fail_msg("accept_timeout", "request never accepted");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge pclk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) fail_msg("idle_timeout", "req_ready never returned");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int a0, a1, n;

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_cs", cs, 1'b1);
        check("rst_wr", wr, 1'b1);
        check("rst_rd", rd, 1'b1);
        check("rst_rst", rst, 1'b0);
        check("rst_rs", rs, 1'b0);
        check("rst_blk", blk, 1'b0);
        check("rst_data_out", data_out, 16'h0);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0);
        @(posedge pclk);
        #1 prst = 1'b0;

        // Power-up: rst low phase, then wait phase, busy throughout.
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge pclk);
            if (rst) break;
            n++;
            check("init_busy", {busy, req_ready, cs}, 3'b101);
        end
        check("init_rst_len", n, T_RSTL);
        n = 0;
        while (!req_ready && n < 300) begin
            n++;
            check("wait_busy", {busy, rst, cs}, 3'b111);
            @(negedge pclk);
        end
        check("init_wait_len", n, T_RSTW);
        check("idle_pins", {busy, cs, wr, rd, data_oe, rst}, 6'b011101);

        // Back-to-back command then data write.
        wr_q.push_back({1'b0, 16'h002C});
        do_req(1'b0, 1'b0, 16'h002C, a0);
        wr_q.push_back({1'b1, 16'hF800});
        do_req(1'b1, 1'b0, 16'hF800, a1);
        check("wr_spacing", a1 - a0, T_WRL + T_WRH + 1);
        wait_idle();

        // Back-to-back reads, then a read with a different word.
        data_in = 16'h9341;
        rd_q.push_back(16'h9341);
        do_req(1'b0, 1'b1, 16'h0000, a0);
        rd_q.push_back(16'h9341);
        do_req(1'b1, 1'b1, 16'h0000, a1);
        check("rd_spacing", a1 - a0, T_RDL + T_RDH + 1);
        wait_idle();
        data_in = 16'hA5C3;
        rd_q.push_back(16'hA5C3);
        do_req(1'b1, 1'b1, 16'h0000, a0);
        wait_idle();
        data_in = 16'h0F0F;
        repeat (3) @(negedge pclk);
        check("rsp_hold", rsp_data, 16'hA5C3);

        // init_req and req_valid together in IDLE: re-init wins.
        wait_idle();
        wr_q.push_back({1'b1, 16'h1111});
        init_req  = 1'b1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_rd    = 1'b0;
        req_data  = 16'h1111;
        @(posedge pclk);
        #1 init_req = 1'b0;
        @(negedge pclk);
        check("reinit_entry", {rst, req_ready, busy, cs, wr}, 5'b00111);
        n = 0;
        while (!req_ready && n < 300) begin
            n++;
            @(negedge pclk);
        end
        check("reinit_len", n, T_RSTL + T_RSTW);
        @(posedge pclk);
        #1 req_valid = 1'b0;
        wait_idle();

        // Reset in the 3rd RD_LO cycle aborts the read without a response.
        data_in = 16'hBEEF;
        do_req(1'b0, 1'b1, 16'h0000, a0);
        @(posedge pclk);
        @(posedge pclk);
        #1 prst = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check("abort_pins", {cs, rd, rst, rsp_valid}, 4'b1100);
        check("abort_rsp_data", rsp_data, 16'h0);
        @(posedge pclk);
        #1 prst = 1'b0;
        wait_idle();

        wr_q.push_back({1'b1, 16'h5A5A});
        do_req(1'b1, 1'b0, 16'h5A5A, a0);
        wait_idle();
        repeat (5) @(negedge pclk);
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 SHALL have parameter T_WRL, default 2, wr low-phase length in pclk cycles (>=1).
REQ-002 SHALL have parameter T_WRH, default 2, wr high-phase length in cycles (>=1).
REQ-003 SHALL have parameter T_RDL, default 5, rd low-phase length in cycles (>=1).
REQ-004 SHALL have parameter T_RDH, default 3, rd high-phase length in cycles (>=1).
REQ-005 SHALL have parameter T_RSTL, default 16, panel rst low time in cycles (>=1).
REQ-006 SHALL have parameter T_RSTW, default 64, post-rst wait before first access, in cycles (>=1).
REQ-007 SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named pclk and prst.
REQ-008 pclk  in  1  system clock, all logic on rising edge.
REQ-009 prst  in  1  synchronous active-high reset.
REQ-010 req_valid  in  1  access request; req_ready  out  1  request accepted when both high on an edge.
REQ-011 req_rs  in  1  0=command, 1=data; req_rd  in  1  0=write, 1=read; req_data  in  16  write word.
REQ-012 rsp_valid  out  1  one-cycle read-result strobe; rsp_data  out  16  read word.
REQ-013 init_req  in  1  request to re-run the panel reset sequence; bl_en  in  1  backlight enable.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 blk, cs, rs, wr, rd, rst  out  1 each  panel pins (cs/wr/rd/rst active-low).
REQ-016 data_out  out  16, data_oe  out  1, data_in  in  16  split bidirectional panel data bus.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states: INIT_RST, INIT_WAIT, IDLE, WR_LO, WR_HI, RD_LO, RD_HI.
REQ-019 INIT_RST: rst=0, cs=1, for T_RSTL cycles, then go to INIT_WAIT.
REQ-020 INIT_WAIT: rst=1 for T_RSTW cycles, then go to IDLE.
REQ-021 IDLE: req_ready=1, cs=1, wr=1, rd=1, data_oe=0, busy=0; req_ready=0 in every other state.
REQ-022 In IDLE, init_req=1 SHALL enter INIT_RST on the next edge and SHALL take priority over req_valid in the same cycle; no request is accepted in that cycle.
REQ-023 init_req SHALL be ignored outside IDLE.
REQ-024 On write accept: the next cycle shows cs=0, rs=req_rs, data_out=req_data, data_oe=1, wr=0.
REQ-025 Write: wr=0 for T_WRL cycles (WR_LO), then wr=1 for T_WRH cycles (WR_HI) with cs, rs and data held, then return to IDLE.
REQ-026 On read accept: the next cycle shows cs=0, rs=req_rs, data_oe=0, rd=0.
REQ-027 Read: rd=0 for T_RDL cycles (RD_LO), then rd=1 for T_RDH cycles (RD_HI), then return to IDLE.
REQ-028 data_in SHALL be captured on the edge ending the last RD_LO cycle; rsp_data SHALL take that value and rsp_valid=1 for exactly the first RD_HI cycle.
REQ-029 rsp_data SHALL hold its value until the next read; rsp_valid SHALL be 0 at all other times.
REQ-030 Minimum write period SHALL be T_WRL+T_WRH+1 cycles; minimum read period T_RDL+T_RDH+1 cycles (one IDLE cycle between accesses).
REQ-031 rd and wr SHALL never be low simultaneously; wr/rd SHALL be low only while cs=0.
REQ-032 blk SHALL follow bl_en with one cycle latency, independent of FSM state, including during INIT.
REQ-033 Phase counters SHALL be 16 bits wide, load the phase length minus 1 on state entry, and transition at 0.

Reset
REQ-034 While prst=1 at an edge: state INIT_RST with counter reloaded, rst=0, cs=1, wr=1, rd=1, rs=0, blk=0, data_out=0, data_oe=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=1.
REQ-035 prst asserted mid-access SHALL abort the access on that edge, produce no rsp_valid, and restart the full init sequence.

Verification
REQ-036 Power-up, defaults: release prst -> rst=0 for 16 cycles, rst=1 for 64 cycles, then req_ready=1; busy=1 throughout the init sequence.
REQ-037 Write cmd 0x002C then data 0xF800 back-to-back -> each shows wr low 2 and high 2 cycles; rs=0 then 1; data_oe=1 only during the access; accept-to-accept spacing is 5 cycles.
REQ-038 Read with data_in=0x9341 -> rd low 5 cycles; rsp_valid is a single pulse in the first rd-high cycle with rsp_data=0x9341; data_oe stays 0.
REQ-039 init_req and req_valid high together in IDLE -> INIT_RST is entered, the request is not accepted, and it is accepted after the 80-cycle reinit.
REQ-040 prst pulsed in the 3rd RD_LO cycle -> the next cycle shows cs=1, rd=1, rst=0, and no rsp_valid occurs.
REQ-041 bl_en toggled during INIT and during a write -> blk follows with 1-cycle latency; the write timing is unaffected.
